fpu_request_arbiter: RTL and testbench
======================================

// Module: fpu_request_arbiter
// PURPOSE
//  Shares the single floating-point unit between two requesters (req port 0, req port 1).
//  Performs round-robin arbitration and captures the winner's operation and operands.
//  Runs the FPU start/done handshake and returns the result to the owning requester.
//  A watchdog aborts any operation whose FPU done never returns. Sits between the core
//  and the FPU control unit.
// PARAMETERS
//  DATA_WIDTH  32             operand/result width
//  TIMEOUT     64             max cycles in ISSUE+WAIT_DONE before abort (>=2)
//  NAN_RESULT  32'h7FC00000   result returned on timeout (quiet NaN)
// PORTS
//  clk            in   1    single clock, rising edge
//  reset          in   1    asynchronous, active-low reset
//  req0/req1      in   1    request; held high with op/operands stable until gntN
//  op0/op1        in   2    FPU operation code (00 = add)
//  a0/a1, b0/b1   in   DW   operands
//  gnt0/gnt1      out  1    1-cycle pulse: request accepted, operands captured
//  resp_valid0/1  out  1    1-cycle pulse: result for port N on resp_result
//  resp_result    out  DW   result; holds its value until the next response
//  resp_error     out  1    qualifies resp_validN; 1 = timeout abort
//  busy           out  1    high in every state except IDLE
//  fpu_start      out  1    start to FPU
//  fpu_operation  out  2    registered op; stable from ISSUE through RESPOND
//  fpu_op_a/b     out  DW   registered operands; same stability as fpu_operation
//  fpu_done       in   1    FPU done: high when the FPU is idle, low while it is operating
//  fpu_result     in   DW   FPU result; valid when fpu_done rises
// BEHAVIOUR
//  Reset (reset==0): state=IDLE; all outputs 0; last_grant=1, so port 0 wins first.
//    Reset is asynchronous and may occur mid-operation: the in-flight operation is
//    dropped and no resp_valid is ever issued for it.
//  All outputs are registered.
//  IDLE
//    No requests: stay in IDLE.
//    Exactly one req: grant it.
//    Both req: grant the port != last_grant.
//    On grant (same edge): gntN=1, capture opN/aN/bN into fpu_* regs, owner=N,
//      last_grant=N, timer=0, go to ISSUE.
//  ISSUE
//    fpu_start=1 every cycle; timer increments.
//    fpu_done==0 sampled: fpu_start<=0, go to WAIT_DONE.
//  WAIT_DONE
//    fpu_start=0; timer increments.
//    fpu_done==1 sampled: resp_result<=fpu_result, resp_error<=0, go to RESPOND.
//  Timeout
//    timer reaching TIMEOUT-1 in ISSUE or WAIT_DONE (with no done event that cycle):
//      fpu_start<=0, resp_result<=NAN_RESULT, resp_error<=1, go to RESPOND.
//    A done event in the same cycle as expiry takes priority over the timeout.
//  RESPOND
//    resp_valid[owner]=1 for exactly one cycle, then IDLE.
//    resp_error holds until the next response.
//  Latency: gnt lands one edge after req is sampled in IDLE.
//    resp_valid lands two edges after fpu_done rises is sampled.
//    Minimum gap between grants is 3 cycles + FPU time.
//  Requests are sampled only in IDLE: a req raised mid-operation waits; a req dropped
//    before gnt is never served.
//  gnt and resp_valid are never asserted for both ports in the same cycle.
//  timer width: clog2(TIMEOUT)+1; it saturates and never wraps.
// TESTING
//  1. Single add: req0, op0=00, a0=3F800000, b0=40000000; FPU model lowers done 2 cycles
//     after start and raises it 10 cycles later with 40400000.
//     -> gnt0 one pulse; fpu_start high until done low; resp_valid0 one pulse;
//        resp_result=40400000; resp_error=0.
//  2. req0 and req1 both raised in the same cycle after reset
//     -> gnt0 first, gnt1 after RESPOND; each resp_validN matches its port.
//  3. req0 and req1 held high for 4 transactions -> grants alternate 0,1,0,1.
//  4. FPU model holds done=1 forever
//     -> after 64 cycles: resp_valid0 with resp_error=1, resp_result=7FC00000;
//        fpu_start=0; then IDLE.
//  5. reset driven low during WAIT_DONE
//     -> all outputs 0 immediately; no resp_valid after release;
//        next request completes normally.
//  6. a0 changed the cycle after gnt0 -> fpu_op_a keeps the captured value until RESPOND.

Source files
------------

// File: rtl/fpu_request_arbiter_if.sv
// Requester and FPU handshake bundle for the FPU request arbiter.
// slave: arbiter side; master: requesters plus FPU model side.
interface fpu_request_arbiter_if #(
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic [1:0]    op0;
  logic [1:0]    op1;
  logic [DW-1:0] a0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;
  logic          gnt0;
  logic          gnt1;
  logic          resp_valid0;
  logic          resp_valid1;
  logic [DW-1:0] resp_result;
  logic          resp_error;
  logic          busy;
  logic          fpu_start;
  logic [1:0]    fpu_operation;
  logic [DW-1:0] fpu_op_a;
  logic [DW-1:0] fpu_op_b;
  logic          fpu_done;
  logic [DW-1:0] fpu_result;

  modport slave (
    input  req0, req1, op0, op1,
    input  a0, a1, b0, b1,
    input  fpu_done, fpu_result,
    output gnt0, gnt1,
    output resp_valid0, resp_valid1,
    output resp_result, resp_error, busy,
    output fpu_start, fpu_operation,
    output fpu_op_a, fpu_op_b
  );

  modport master (
    output req0, req1, op0, op1,
    output a0, a1, b0, b1,
    output fpu_done, fpu_result,
    input  gnt0, gnt1,
    input  resp_valid0, resp_valid1,
    input  resp_result, resp_error, busy,
    input  fpu_start, fpu_operation,
    input  fpu_op_a, fpu_op_b
  );
endinterface

// File: rtl/fpu_request_arbiter.sv
// Round-robin arbiter sharing one FPU between two requesters, with watchdog.
// Ports: clk, reset (async active-low), bus (fpu_request_arbiter_if.slave).
module fpu_request_arbiter #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 64,
  parameter logic [DATA_WIDTH-1:0] NAN_RESULT = 32'h7FC00000
) (
  input logic                  clk,
  input logic                  reset,
  fpu_request_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_DONE, RESPOND
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  rv0_q, rv0_d;
  logic                  rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [TW-1:0]         timer_inc;
  logic                  expired;
  logic                  abort;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timer_d   = timer_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    result_d  = result_q;
    error_d   = error_q;
    start_d   = start_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    abort     = 1'b0;
    // saturating timer: never wraps back under the limit
    timer_inc = (timer_q == T_MAX) ? timer_q
                                   : timer_q + 1'b1;
    expired   = (timer_q >= T_LAST);
    unique case (state_q)
      IDLE: begin
        // port 0 wins a tie only if port 1 was last served
        if (bus.req0 && (!bus.req1 || last_q)) begin
          gnt0_d  = 1'b1;
          owner_d = 1'b0;
          last_d  = 1'b0;
          op_d    = bus.op0;
          a_d     = bus.a0;
          b_d     = bus.b0;
          timer_d = '0;
          start_d = 1'b1;
          state_d = ISSUE;
        end else if (bus.req1) begin
          gnt1_d  = 1'b1;
          owner_d = 1'b1;
          last_d  = 1'b1;
          op_d    = bus.op1;
          a_d     = bus.a1;
          b_d     = bus.b1;
          timer_d = '0;
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_inc;
        if (!bus.fpu_done) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_inc;
        if (bus.fpu_done) begin
          result_d = bus.fpu_result;
          error_d  = 1'b0;
          state_d  = RESPOND;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      RESPOND: begin
        rv0_d   = !owner_q;
        rv1_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      start_d  = 1'b0;
      result_d = NAN_RESULT;
      error_d  = 1'b1;
      state_d  = RESPOND;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      timer_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      result_q <= result_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign bus.gnt0          = gnt0_q;
  assign bus.gnt1          = gnt1_q;
  assign bus.resp_valid0   = rv0_q;
  assign bus.resp_valid1   = rv1_q;
  assign bus.resp_result   = result_q;
  assign bus.resp_error    = error_q;
  assign bus.busy          = busy_q;
  assign bus.fpu_start     = start_q;
  assign bus.fpu_operation = op_q;
  assign bus.fpu_op_a      = a_q;
  assign bus.fpu_op_b      = b_q;
endmodule

// File: tb/tb_fpu_request_arbiter.sv
// Scoreboard bench for fpu_request_arbiter with a small FPU model.
// Drivers push expectations on issue; a negedge monitor pops and compares.
module tb_fpu_request_arbiter;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic hang  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   resp_seen = 0;

  txn_t stim_q0[$];
  txn_t stim_q1[$];
  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   exp_gnt[$];

  fpu_request_arbiter_if #(.DW(32)) bus();

  fpu_request_arbiter #(
    .DATA_WIDTH(32),
    .TIMEOUT(64),
    .NAN_RESULT(32'h7FC00000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  // hand-computed IEEE-754 single results; unknown pairs give a marker
  function automatic logic [31:0] fpu_calc(
      input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {2'b00, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {2'b01, 32'h40A00000, 32'h3F800000}: return 32'h40800000;
      {2'b00, 32'h3F000000, 32'h3FC00000}: return 32'h40000000;
      {2'b00, 32'h41200000, 32'h3F800000}: return 32'h41300000;
      {2'b00, 32'h40400000, 32'h40A00000}: return 32'h41000000;
      {2'b00, 32'h42C80000, 32'hC2C80000}: return 32'h00000000;
      {2'b00, 32'h3F800000, 32'h40400000}: return 32'h40800000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // FPU model: done falls 2 cycles after start is seen, rises 10 later
  logic fbusy;
  int   fcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fbusy <= 1'b0;
      fcnt  <= 0;
      bus.fpu_done   <= 1'b1;
      bus.fpu_result <= '0;
    end else if (!fbusy) begin
      if (bus.fpu_start && !hang) begin
        fbusy <= 1'b1;
        fcnt  <= 0;
      end
    end else begin
      fcnt <= fcnt + 1;
      if (fcnt == 1) bus.fpu_done <= 1'b0;
      if (fcnt == 11) begin
        bus.fpu_done   <= 1'b1;
        bus.fpu_result <= fpu_calc(bus.fpu_operation,
                                   bus.fpu_op_a, bus.fpu_op_b);
        fbusy <= 1'b0;
      end
    end
  end

  task automatic set_port(input bit p, input logic r,
                          input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b);
    if (p) begin
      bus.req1 = r; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end else begin
      bus.req0 = r; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end
  endtask

  task automatic drive_port(input bit p);
    txn_t t;
    int   n;
    forever begin
      @(negedge clk);
      if (p ? stim_q1.size() != 0 : stim_q0.size() != 0) begin
        if (p) t = stim_q1.pop_front();
        else   t = stim_q0.pop_front();
        if (p) exp_q1.push_back(t);
        else   exp_q0.push_back(t);
        set_port(p, 1'b1, t.op, t.a, t.b);
        n = 0;
        while (!(p ? bus.gnt1 : bus.gnt0) && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (n >= 300) begin
          checks++;
          errors++;
          $display("FAIL gnt_timeout port%0d: got none required 1", p);
        end
        // disturb operands right after the grant
        set_port(p, 1'b0, ~t.op, ~t.a, ~t.b);
      end
    end
  endtask

  initial begin
    set_port(1'b0, 1'b0, 2'b00, '0, '0);
    set_port(1'b1, 1'b0, 2'b00, '0, '0);
    fork
      drive_port(1'b0);
      drive_port(1'b1);
    join_none
  end

  // monitor / scoreboard
  logic [65:0] held = '0;
  int          gnt_cyc = 0;
  txn_t        cur;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.gnt0 || bus.gnt1) begin
        chk("gnt_onehot", 128'(bus.gnt0 & bus.gnt1), 0);
        if (exp_gnt.size() == 0) begin
          chk("unexpected_gnt", 128'(bus.gnt1), 128'hF);
        end else begin
          chk("gnt_order", 128'(bus.gnt1),
              128'(exp_gnt.pop_front()));
        end
        gnt_cyc = cyc;
        chk("start_on_gnt", 128'(bus.fpu_start), 1);
        if (bus.gnt1 ? exp_q1.size() != 0 : exp_q0.size() != 0) begin
          cur  = bus.gnt1 ? exp_q1[0] : exp_q0[0];
          held = {cur.op, cur.a, cur.b};
          chk("gnt_capture", 128'({bus.fpu_operation,
              bus.fpu_op_a, bus.fpu_op_b}), 128'(held));
        end
      end else if (bus.busy) begin
        chk("op_hold", 128'({bus.fpu_operation,
            bus.fpu_op_a, bus.fpu_op_b}), 128'(held));
      end
      if (bus.resp_valid0 || bus.resp_valid1) begin
        resp_seen++;
        chk("resp_onehot",
            128'(bus.resp_valid0 & bus.resp_valid1), 0);
        if (bus.resp_valid1 ? exp_q1.size() == 0
                            : exp_q0.size() == 0) begin
          chk("unexpected_resp", 128'(bus.resp_valid1), 128'hF);
        end else begin
          if (bus.resp_valid1) cur = exp_q1.pop_front();
          else                 cur = exp_q0.pop_front();
          chk("resp_result", 128'(bus.resp_result), 128'(cur.res));
          chk("resp_error", 128'(bus.resp_error), 128'(cur.err));
          chk("resp_latency", 128'(cyc - gnt_cyc), 128'(cur.lat));
          chk("start_low_at_resp", 128'(bus.fpu_start), 0);
          chk("idle_at_resp", 128'(bus.busy), 0);
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({bus.gnt0, bus.gnt1, bus.resp_valid0,
                 bus.resp_valid1, bus.resp_result,
                 bus.resp_error, bus.busy, bus.fpu_start,
                 bus.fpu_operation, bus.fpu_op_a, bus.fpu_op_b});
  endfunction

  function automatic txn_t mk(input logic [1:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] res, input logic err, input int lat);
    txn_t t;
    t.op = op; t.a = a; t.b = b;
    t.res = res; t.err = err; t.lat = lat;
    return t;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(stim_q0.size() == 0 && stim_q1.size() == 0 &&
             exp_q0.size() == 0 && exp_q1.size() == 0 &&
             exp_gnt.size() == 0 && !bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy required idle", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", all_outs(), 0);
    @(negedge clk);
    reset = 1'b1;

    // single add
    @(posedge clk);
    exp_gnt.push_back(0);
    stim_q0.push_back(mk(2'b00, 32'h3F800000, 32'h40000000,
                         32'h40400000, 1'b0, 15));
    wait_idle("single");

    // simultaneous requests right after reset
    pulse_reset();
    @(posedge clk);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    stim_q0.push_back(mk(2'b00, 32'h3F800000, 32'h3F800000,
                         32'h40000000, 1'b0, 15));
    stim_q1.push_back(mk(2'b01, 32'h40A00000, 32'h3F800000,
                         32'h40800000, 1'b0, 15));
    wait_idle("both");

    // held requests alternate
    @(posedge clk);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    stim_q0.push_back(mk(2'b00, 32'h3F000000, 32'h3FC00000,
                         32'h40000000, 1'b0, 15));
    stim_q0.push_back(mk(2'b00, 32'h41200000, 32'h3F800000,
                         32'h41300000, 1'b0, 15));
    stim_q1.push_back(mk(2'b00, 32'h40400000, 32'h40A00000,
                         32'h41000000, 1'b0, 15));
    stim_q1.push_back(mk(2'b00, 32'h42C80000, 32'hC2C80000,
                         32'h00000000, 1'b0, 15));
    wait_idle("alternate");

    // FPU never answers: watchdog abort
    pulse_reset();
    hang = 1'b1;
    @(posedge clk);
    exp_gnt.push_back(0);
    stim_q0.push_back(mk(2'b00, 32'h40400000, 32'h3F800000,
                         32'h7FC00000, 1'b1, 65));
    repeat (30) @(negedge clk);
    chk("start_held_in_issue", 128'({bus.fpu_start, bus.busy}), 3);
    wait_idle("timeout");
    hang = 1'b0;

    // reset during WAIT_DONE drops the operation
    @(posedge clk);
    exp_gnt.push_back(0);
    stim_q0.push_back(mk(2'b00, 32'h3F800000, 32'h40000000,
                         32'h40400000, 1'b0, 15));
    n = 0;
    while (!(exp_gnt.size() == 0 && bus.fpu_done == 1'b0 &&
             !bus.fpu_start) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wait_done", 128'(n < 200), 1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("midop_reset_outputs", all_outs(), 0);
    exp_q0.delete();
    seen = resp_seen;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_resp_after_reset", 128'(resp_seen - seen), 0);
    @(posedge clk);
    exp_gnt.push_back(0);
    stim_q0.push_back(mk(2'b00, 32'h3F800000, 32'h40400000,
                         32'h40800000, 1'b0, 15));
    wait_idle("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running required done");
    $fatal(1, "global timeout");
  end
endmodule
